// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial bit-stream transmitter.
//   Words are accepted on a valid/ready handshake and shifted out MSB-first,
//   one bit per clock while tx_en is high. tx_en low stalls the stream and
//   drops dout_vld for that cycle. Back-to-back words produce a gapless stream.
//
// Optional feature macro: SEQ_SERIALIZER_PARITY_EN
//   When defined, an even-parity bit (XOR of the word) follows each word's
//   data bits, so each word takes WIDTH+1 valid cycles.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   word_in   parallel word, held stable while word_vld && !word_rdy
//   word_vld  word_in valid
//   word_rdy  block accepts word_in this cycle (combinational)
//   tx_en     1 = emit a bit this cycle, 0 = stall
//   dout      serial data (registered)
//   dout_vld  dout qualifier (registered)
//   busy      state != IDLE
//   word_cnt  count of fully transmitted words, wraps
module seq_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_vld,
  output logic             word_rdy,
  input  logic             tx_en,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SEQ_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  logic par_bit;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t          state, next_state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             bit_last;
  logic             emit;
  logic             done;    // emit that completes a word
  logic             accept;

  assign bit_last = (bit_cnt == BW'(WIDTH - 1));
  assign emit     = tx_en && (state != IDLE);
  assign accept   = word_vld && word_rdy;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    word_rdy   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // Accept regardless of tx_en; loading never emits.
        word_rdy = 1'b1;
        if (word_vld) next_state = SHIFT;
      end
      SHIFT: begin
        if (tx_en && bit_last) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
          next_state = PAR;
`else
          // Last data bit doubles as the back-to-back accept point.
          word_rdy   = 1'b1;
          done       = 1'b1;
          next_state = word_vld ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SEQ_SERIALIZER_PARITY_EN
      PAR: begin
        if (tx_en) begin
          word_rdy   = 1'b1;
          done       = 1'b1;
          next_state = word_vld ? SHIFT : IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      word_cnt <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      dout_vld <= emit;
      if (emit) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
        dout <= (state == PAR) ? par_bit : shreg[WIDTH-1];
`else
        dout <= shreg[WIDTH-1];
`endif
      end
      // A load on the last-bit edge wins: dout already took the old MSB.
      if (accept) begin
        shreg   <= word_in;
        bit_cnt <= '0;
`ifdef SEQ_SERIALIZER_PARITY_EN
        par_bit <= ^word_in;
`endif
      end else if (state == SHIFT && tx_en) begin
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
      end
      if (done) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule
